// File: rtl/spi_boot_loader_pkg.sv
// Shared definitions for the SPI boot loader: FSM state encoding, error codes
// and header field positions.
package spi_boot_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    typedef enum logic [1:0] {
        ErrSync    = 2'd0,
        ErrRange   = 2'd1,
        ErrCsum    = 2'd2,
        ErrTimeout = 2'd3
    } err_e;

    // Header word: {sync[31:24], reserved[23:16], count[15:0]}
    localparam int unsigned HdrSyncMsb  = 31;
    localparam int unsigned HdrSyncLsb  = 24;
    localparam int unsigned HdrCountMsb = 15;
    localparam int unsigned HdrCountLsb = 0;

endpackage

// File: rtl/spi_word_edge_detect.sv
// Registers the receiver word-valid and produces a one-cycle accept pulse on its
// rising edge, so a valid held high for several cycles counts as one word.
// Ports:
//   i_clk, i_rst  clock and asynchronous active-high reset
//   i_rx_dv       word-valid from the SPI receiver
//   o_accept      high for the first cycle of each i_rx_dv high period
module spi_word_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx_dv,
    output logic o_accept
);

    logic dv_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dv_q <= 1'b0;
        end else begin
            dv_q <= i_rx_dv;
        end
    end

    assign o_accept = i_rx_dv & ~dv_q;

endmodule

// File: rtl/spi_boot_loader.sv
// Boot image loader: parses framed words from the SPI receiver
// (HEADER, BASE, count DATA words, CHECK), writes the payload to memory and
// hands memory to the core only after a range- and checksum-valid image.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_rx_dv, i_rx_word      received word and its valid
//   i_clear                 leaves DONE/ERROR back to IDLE
//   o_mem_*                 single-port memory write interface
//   o_core_select           1 = core owns memory
//   o_busy/o_done/o_error   status; o_err_code valid while o_error
//   o_word_cnt              payload words written in the current frame
// ADDR_WIDTH is expected to be in 16..32.
module spi_boot_loader
    import spi_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH_WORDS = 4096,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_dv,
    input  logic [31:0]           i_rx_word,
    input  logic                  i_clear,
    output logic                  o_mem_en,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic [3:0]            o_mem_be,
    output logic                  o_core_select,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [1:0]            o_err_code,
    output logic [15:0]           o_word_cnt
);

    logic accept;

    spi_word_edge_detect u_edge (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_rx_dv  (i_rx_dv),
        .o_accept (accept)
    );

    state_e                state_q, state_d;
    err_e                  err_q, err_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [31:0]           acc_q, acc_d;
    logic [31:0]           tmr_q, tmr_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic [ADDR_WIDTH:0]   range_end;
    logic [31:0]           csum;
    logic [31:0]           tmr_inc;
    logic                  busy;

    // One extra bit so base + count cannot wrap past the depth check
    assign range_end = {1'b0, i_rx_word[ADDR_WIDTH-1:0]} + (ADDR_WIDTH + 1)'(count_q);
    assign csum      = acc_q + i_rx_word;
    assign tmr_inc   = tmr_q + 32'd1;
    assign busy      = (state_q == StAddr) || (state_q == StData) || (state_q == StCheck);

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        count_d     = count_q;
        word_cnt_d  = word_cnt_q;
        addr_cnt_d  = addr_cnt_q;
        acc_d       = acc_q;
        tmr_d       = '0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (i_rx_word[HdrSyncMsb:HdrSyncLsb] == SYNC_BYTE &&
                        i_rx_word[HdrCountMsb:HdrCountLsb] != 16'd0) begin
                        count_d = i_rx_word[HdrCountMsb:HdrCountLsb];
                        state_d = StAddr;
                    end else begin
                        err_d   = ErrSync;
                        state_d = StError;
                    end
                end
            end
            StAddr: begin
                if (accept) begin
                    if (range_end > (ADDR_WIDTH + 1)'(MEM_DEPTH_WORDS)) begin
                        err_d   = ErrRange;
                        state_d = StError;
                    end else begin
                        addr_cnt_d = i_rx_word[ADDR_WIDTH-1:0];
                        acc_d      = '0;
                        word_cnt_d = '0;
                        state_d    = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = addr_cnt_q;
                    mem_wdata_d = i_rx_word;
                    addr_cnt_d  = addr_cnt_q + 1'b1;
                    word_cnt_d  = word_cnt_q + 16'd1;
                    acc_d       = csum;
                    if (word_cnt_q + 16'd1 == count_q) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (accept) begin
                    if (csum == 32'd0) begin
                        state_d = StDone;
                    end else begin
                        err_d   = ErrCsum;
                        state_d = StError;
                    end
                end
            end
            StDone, StError: begin
                // Clear wins over a simultaneous word; words are otherwise ignored
                if (i_clear) begin
                    err_d   = ErrSync;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Inter-word timeout; an accept on the expiry cycle takes priority
        if (busy && !accept) begin
            tmr_d = tmr_inc;
            if (tmr_inc == TIMEOUT_CYCLES - 1) begin
                err_d   = ErrTimeout;
                state_d = StError;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            err_q       <= ErrSync;
            count_q     <= '0;
            word_cnt_q  <= '0;
            addr_cnt_q  <= '0;
            acc_q       <= '0;
            tmr_q       <= '0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            count_q     <= count_d;
            word_cnt_q  <= word_cnt_d;
            addr_cnt_q  <= addr_cnt_d;
            acc_q       <= acc_d;
            tmr_q       <= tmr_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign o_mem_en      = mem_wr_q;
    assign o_mem_wr_en   = mem_wr_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_mem_be      = 4'b1111;
    assign o_core_select = (state_q == StDone);
    assign o_busy        = busy;
    assign o_done        = (state_q == StDone);
    assign o_error       = (state_q == StError);
    assign o_err_code    = err_q;
    assign o_word_cnt    = word_cnt_q;

endmodule

// File: doc/spi_boot_loader.md
Name: spi_boot_loader

Overview:
- Sits directly downstream of the SPI slave word receiver, in the i_clk domain.
- Parses each received 32-bit word as a framed boot image and writes the payload into instruction/data memory through a single-port write interface.
- Holds the RV32I core off the memory (core_select = 0) until a complete, range-checked, checksum-valid image has loaded, then hands memory ownership to the core.

Parameters:
- ADDR_WIDTH, 32, width of o_mem_addr (word address).
- MEM_DEPTH_WORDS, 4096, number of writable memory words; base+count-1 must be below this.
- SYNC_BYTE, 8'hA5, required value of header bits [31:24].
- TIMEOUT_CYCLES, 1000000, maximum i_clk cycles allowed between words inside a frame.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_dv  in  1  word-valid from the SPI receiver; may stay high for 1 or more cycles per word.
- i_rx_word  in  32  received word; stable while i_rx_dv is high.
- i_clear  in  1  one-cycle pulse; leaves ERROR or DONE and returns to IDLE.
- o_mem_en  out  1  memory enable, high on a write cycle.
- o_mem_wr_en  out  1  write strobe, one cycle per payload word.
- o_mem_addr  out  ADDR_WIDTH  word write address.
- o_mem_wdata  out  32  write data.
- o_mem_be  out  4  byte enables, constant 4'b1111 on writes.
- o_core_select  out  1  0 = loader owns memory, 1 = core owns memory.
- o_busy  out  1  high in ADDR, DATA and CHECK.
- o_done  out  1  high in DONE.
- o_error  out  1  high in ERROR.
- o_err_code  out  2  0 = bad sync or zero count, 1 = range, 2 = checksum, 3 = timeout; valid while o_error is high.
- o_word_cnt  out  16  payload words written in the current frame.

Behaviour:
- Reset values: all outputs 0, except o_mem_be = 4'b1111. State = IDLE, checksum accumulator = 0.
- Word accept: register i_rx_dv every cycle. A word is accepted only on a rising edge (i_rx_dv = 1 and the previous sample = 0). A multi-cycle-high dv therefore counts as one word.
- Frame format: HEADER {SYNC_BYTE, 8'h00, count[15:0]}, then BASE (word address), then count DATA words, then CHECK. The frame is valid when the 32-bit wrap sum of all DATA words plus CHECK equals 0.
- IDLE: on an accepted word:
  - [31:24] = SYNC_BYTE and count != 0: latch count, go to ADDR.
  - Otherwise: go to ERROR with code 0. Bits [23:16] are ignored.
- ADDR: on an accepted word:
  - base + count > MEM_DEPTH_WORDS (compare at ADDR_WIDTH+1 bits, no wrap): go to ERROR with code 1.
  - Otherwise: latch the base into the address counter, clear the accumulator and o_word_cnt, go to DATA.
- DATA: each accepted word produces exactly one write cycle, one cycle after the accept edge:
  - o_mem_en = o_mem_wr_en = 1, o_mem_addr = current address, o_mem_wdata = the word.
  - Address increments by 1, o_word_cnt increments, accumulator += word (mod 2^32).
  - Go to CHECK after the count-th write.
- CHECK: on an accepted word, accumulator + word == 0 goes to DONE; otherwise ERROR with code 2.
- DONE: o_core_select = 1, o_done = 1. Further words are ignored. i_clear goes to IDLE and sets o_core_select = 0.
- ERROR: o_core_select stays 0. Words are ignored. i_clear goes to IDLE and clears o_error.
- Timeout: a counter runs in ADDR, DATA and CHECK and resets on every accepted word. Reaching TIMEOUT_CYCLES-1 goes to ERROR with code 3. The counter is idle in every other state.
- Simultaneous events:
  - i_clear together with an accept edge in DONE or ERROR: the clear wins and the word is dropped.
  - Timeout expiry on the same cycle as an accept edge: the accept wins.
- Reset mid-frame: returns to IDLE immediately. A write already issued is not retracted; the partial image stays in memory with o_core_select = 0.
- o_mem_en and o_mem_wr_en are 0 in every cycle that is not a write cycle.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, ADDR, DATA, CHECK, DONE, ERROR;
  - error codes: ERR_SYNC, ERR_RANGE, ERR_CSUM, ERR_TIMEOUT;
  - header field bit positions.
- Natural sub-module: spi_word_edge_detect (dv register plus rising-edge accept pulse), reused by any other consumer of the receiver.
- Everything else stays in one FSM module.

Test Plan:
- Header 0xA5000003, base 0x10, data 1, 2, 3, check 0xFFFFFFFA -> writes addr 0x10/0x11/0x12 with 1/2/3, o_word_cnt = 3, o_done = 1, o_core_select = 1.
- Same frame with dv held high 2 cycles per word -> exactly 3 write pulses, identical result.
- Header 0x5A000003 -> o_error = 1, o_err_code = 0, no writes. Header 0xA5000000 -> also code 0.
- Header 0xA5000004, base 4093 with MEM_DEPTH_WORDS = 4096 -> o_err_code = 1, no writes. Base 4092 -> accepted.
- Valid frame with check 0x00000000 -> 3 writes, then o_err_code = 2, o_core_select = 0. i_clear -> IDLE, and the next valid frame completes.
- TIMEOUT_CYCLES = 100, stop after BASE -> o_err_code = 3 at cycle 99 after the last accept. Assert i_rst mid-DATA -> all outputs return to reset values.
